// File: rtl/bpu_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bpu_pkg;

  // One BTB entry. The tag field is wide enough for the smallest legal BTB;
  // unused upper tag bits are stored as zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic        is_jmp;
  } btb_entry_t;

  // Weakly not-taken reset value for a counter of width w.
  function automatic logic [31:0] cnt_reset(int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Saturating up/down step of a w-bit counter.
  function automatic logic [31:0] sat_update(logic [31:0] cnt, logic up, int unsigned w);
    logic [31:0] max;
    max = (32'd1 << w) - 32'd1;
    if (up) begin
      return (cnt == max) ? cnt : cnt + 32'd1;
    end
    return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_bpu_if.sv
// Fetch-side lookup and execute-side resolve signals of the gshare predictor.
interface gshare_bpu_if #(
  parameter int unsigned GHR_W = 8
) ();

  logic             fetch;
  logic [31:0]      fetch_pc;
  logic             predict_taken;
  logic             predict_valid;
  logic [31:0]      predict_pc;
  logic [GHR_W-1:0] predict_ghr;
  logic             exe_valid;
  logic             exe_is_br;
  logic [31:0]      exe_pc;
  logic             exe_taken;
  logic [31:0]      exe_target;
  logic [GHR_W-1:0] exe_ghr;
  logic             exe_mispredict;

  // IFU / execute side
  modport master (
    output fetch, fetch_pc, exe_valid, exe_is_br, exe_pc, exe_taken, exe_target,
           exe_ghr, exe_mispredict,
    input  predict_taken, predict_valid, predict_pc, predict_ghr
  );

  // Predictor side
  modport slave (
    input  fetch, fetch_pc, exe_valid, exe_is_br, exe_pc, exe_taken, exe_target,
           exe_ghr, exe_mispredict,
    output predict_taken, predict_valid, predict_pc, predict_ghr
  );

endinterface

// File: rtl/gshare_btb.sv
// Direct-mapped BTB: combinational hit/type peek, registered hit/target port,
// single write port. Reads always see the pre-write contents.
module gshare_btb
  import bpu_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  localparam int unsigned IW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lk_en,
  input  logic [IW-1:0] lk_idx,
  input  logic [29:0]   lk_tag,
  output logic          lk_hit,
  output logic          lk_is_jmp,
  output logic          rd_hit,
  output logic [31:0]   rd_target,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [29:0]   wr_tag,
  input  logic [31:0]   wr_target,
  input  logic          wr_is_jmp
);

  btb_entry_t  mem_q [SIZE];
  btb_entry_t  entry;
  logic        rd_hit_q;
  logic [31:0] rd_target_q;

  // Combinational lookup of the indexed entry
  always_comb begin
    entry     = mem_q[lk_idx];
    lk_hit    = entry.valid && (entry.tag == lk_tag);
    lk_is_jmp = entry.is_jmp;
  end

  // Entry storage; only valid bits need a reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, is_jmp: wr_is_jmp};
    end
  end

  // Registered read port, holds while no lookup; target is zero on a miss
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_hit_q    <= 1'b0;
      rd_target_q <= '0;
    end else if (lk_en) begin
      rd_hit_q    <= lk_hit;
      rd_target_q <= lk_hit ? entry.target : 32'd0;
    end
  end

  assign rd_hit    = rd_hit_q;
  assign rd_target = rd_target_q;

endmodule

// File: rtl/gshare_bpu.sv
// Gshare predictor: PC^GHR indexed saturating-counter PHT, speculative GHR
// with mispredict repair, and a direct-mapped BTB for targets and type.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int unsigned PHT_DEPTH = 256,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned BTB_SIZE  = 16
) (
  input logic         clk,
  input logic         rst_n,
  gshare_bpu_if.slave bus
);

  localparam int unsigned AW = $clog2(PHT_DEPTH);
  localparam int unsigned IW = $clog2(BTB_SIZE);

  typedef logic [GHR_W-1:0] ghr_t;

  logic [CNT_W-1:0] pht_q [PHT_DEPTH];
  ghr_t             spec_ghr_q, spec_ghr_d;
  ghr_t             predict_ghr_q;
  logic             predict_taken_q;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic [29:0]      fetch_tag, exe_tag;
  logic             lk_hit, lk_is_jmp, pred_dir;
  logic             unused_pc_bits;

  assign rd_idx    = bus.fetch_pc[2+:AW] ^ AW'(spec_ghr_q);
  assign wr_idx    = bus.exe_pc[2+:AW] ^ AW'(bus.exe_ghr);
  assign fetch_tag = 30'(bus.fetch_pc[31:2+IW]);
  assign exe_tag   = 30'(bus.exe_pc[31:2+IW]);
  assign pred_dir  = lk_hit && (lk_is_jmp || pht_q[rd_idx][CNT_W-1]);

  // Instructions are word aligned
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.exe_pc[1:0]};

  gshare_btb #(
    .SIZE (BTB_SIZE)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_en     (bus.fetch),
    .lk_idx    (bus.fetch_pc[2+:IW]),
    .lk_tag    (fetch_tag),
    .lk_hit    (lk_hit),
    .lk_is_jmp (lk_is_jmp),
    .rd_hit    (bus.predict_valid),
    .rd_target (bus.predict_pc),
    .wr_en     (bus.exe_valid && bus.exe_taken),
    .wr_idx    (bus.exe_pc[2+:IW]),
    .wr_tag    (exe_tag),
    .wr_target (bus.exe_target),
    .wr_is_jmp (!bus.exe_is_br)
  );

  // Next speculative history; repair overrides the fetch-side shift.
  // The sized cast of {h, b} keeps the low GHR_W bits, which also covers GHR_W = 1.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (bus.fetch && lk_hit && !lk_is_jmp) begin
      spec_ghr_d = ghr_t'({spec_ghr_q, pred_dir});
    end
    if (bus.exe_valid && bus.exe_mispredict) begin
      spec_ghr_d = bus.exe_is_br ? ghr_t'({bus.exe_ghr, bus.exe_taken}) : bus.exe_ghr;
    end
  end

  // History register and registered direction/snapshot outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_ghr_q      <= '0;
      predict_taken_q <= 1'b0;
      predict_ghr_q   <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      if (bus.fetch) begin
        predict_taken_q <= pred_dir;
        predict_ghr_q   <= spec_ghr_q;
      end
    end
  end

  // PHT counters, trained by resolved conditional branches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PHT_DEPTH); i++) begin
        pht_q[i] <= CNT_W'(cnt_reset(CNT_W));
      end
    end else if (bus.exe_valid && bus.exe_is_br) begin
      pht_q[wr_idx] <= CNT_W'(sat_update(32'(pht_q[wr_idx]), bus.exe_taken, CNT_W));
    end
  end

  assign bus.predict_taken = predict_taken_q;
  assign bus.predict_ghr   = predict_ghr_q;

endmodule

// File: tb/tb_gshare_bpu.sv
// Self-checking bench for gshare_bpu against an integer-level reference model.
module tb_gshare_bpu;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  gshare_bpu_if #(.GHR_W(8)) bus ();

  gshare_bpu #(
    .PHT_DEPTH (256),
    .GHR_W     (8),
    .CNT_W     (2),
    .BTB_SIZE  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: 256 two-bit counters, 16 BTB entries, 8-bit history
  int          m_pht  [256];
  bit          m_bv   [16];
  logic [31:0] m_btag [16];
  logic [31:0] m_btgt [16];
  bit          m_bjmp [16];
  int          m_ghr;
  bit          e_taken, e_valid;
  logic [31:0] e_pc;
  logic [7:0]  e_ghr;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 0;
    m_ghr   = 0;
    e_taken = 0;
    e_valid = 0;
    e_pc    = 0;
    e_ghr   = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge
  task automatic apply(input bit f, input logic [31:0] fpc, input bit ev, input bit br,
                       input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                       input logic [7:0] eg, input bit mp);
    int ridx, widx, bi, ng;
    bit hit, dir;
    bus.fetch          = f;
    bus.fetch_pc       = fpc;
    bus.exe_valid      = ev;
    bus.exe_is_br      = br;
    bus.exe_pc         = epc;
    bus.exe_taken      = tk;
    bus.exe_target     = tgt;
    bus.exe_ghr        = eg;
    bus.exe_mispredict = mp;
    if (!rst_n) begin
      model_reset();
    end else begin
      ng = m_ghr;
      if (f) begin
        ridx    = int'((fpc >> 2) & 32'hff) ^ m_ghr;
        bi      = int'((fpc >> 2) & 32'hf);
        hit     = m_bv[bi] && (m_btag[bi] == (fpc >> 6));
        dir     = hit && (m_bjmp[bi] || m_pht[ridx] >= 2);
        e_valid = hit;
        e_taken = dir;
        e_pc    = hit ? m_btgt[bi] : 32'd0;
        e_ghr   = 8'(m_ghr);
        if (hit && !m_bjmp[bi]) ng = ((m_ghr << 1) | int'(dir)) & 255;
      end
      if (ev && br) begin
        widx = int'((epc >> 2) & 32'hff) ^ int'(eg);
        if (tk) m_pht[widx] = (m_pht[widx] == 3) ? 3 : m_pht[widx] + 1;
        else    m_pht[widx] = (m_pht[widx] == 0) ? 0 : m_pht[widx] - 1;
      end
      if (ev && tk) begin
        bi         = int'((epc >> 2) & 32'hf);
        m_bv[bi]   = 1;
        m_btag[bi] = epc >> 6;
        m_btgt[bi] = tgt;
        m_bjmp[bi] = !br;
      end
      if (ev && mp) ng = br ? ((int'(eg) << 1) | int'(tk)) & 255 : int'(eg);
      m_ghr = ng;
    end
    @(posedge clk);
    #1;
    bus.fetch     = 1'b0;
    bus.exe_valid = 1'b0;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch_pc(input logic [31:0] pc);
    apply(1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve_br(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                            input logic [7:0] eg);
    apply(0, 0, 1, 1, pc, tk, tgt, eg, 0);
  endtask

  // Not-taken jump mispredict: only effect is spec_ghr <= eg
  task automatic set_ghr(input logic [7:0] eg);
    apply(0, 0, 1, 0, 32'h0000_1000, 0, 0, eg, 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    idle();
    vectors += 4;
    if (bus.predict_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_taken got %0b want 0", bus.predict_taken);
    end
    if (bus.predict_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %0b want 0", bus.predict_valid);
    end
    if (bus.predict_pc !== 32'd0) begin
      miscompares++; $display("FAIL reset_pc got %h want 0", bus.predict_pc);
    end
    if (bus.predict_ghr !== 8'd0) begin
      miscompares++; $display("FAIL reset_ghr got %h want 0", bus.predict_ghr);
    end
    rst_n = 1'b1;
    fetch_pc(32'h100);
    vectors += 3;
    if (bus.predict_valid !== 1'b0) begin
      miscompares++; $display("FAIL cold_valid got %0b want 0", bus.predict_valid);
    end
    if (bus.predict_taken !== 1'b0) begin
      miscompares++; $display("FAIL cold_taken got %0b want 0", bus.predict_taken);
    end
    if (bus.predict_ghr !== 8'd0) begin
      miscompares++; $display("FAIL cold_ghr got %h want 0", bus.predict_ghr);
    end
  endtask

  task automatic test_train();
    resolve_br(32'h100, 1, 32'h200, 0);
    resolve_br(32'h100, 1, 32'h200, 0);
    fetch_pc(32'h100);
    vectors += 3;
    if (bus.predict_valid !== 1'b1) begin
      miscompares++; $display("FAIL train_valid got %0b want 1", bus.predict_valid);
    end
    if (bus.predict_pc !== 32'h200) begin
      miscompares++; $display("FAIL train_pc got %h want 200", bus.predict_pc);
    end
    if (bus.predict_taken !== 1'b1) begin
      miscompares++; $display("FAIL train_taken got %0b want 1", bus.predict_taken);
    end
    set_ghr(0);
    for (int i = 0; i < 4; i++) resolve_br(32'h100, 1, 32'h200, 0);
    fetch_pc(32'h100);
    vectors++;
    if (bus.predict_taken !== 1'b1) begin
      miscompares++; $display("FAIL sat_hi_taken got %0b want 1", bus.predict_taken);
    end
    for (int i = 0; i < 3; i++) resolve_br(32'h100, 0, 32'h200, 0);
    set_ghr(0);
    fetch_pc(32'h100);
    vectors += 2;
    if (bus.predict_taken !== 1'b0) begin
      miscompares++; $display("FAIL sat_lo_taken got %0b want 0", bus.predict_taken);
    end
    if (bus.predict_valid !== 1'b1) begin
      miscompares++; $display("FAIL sat_lo_valid got %0b want 1", bus.predict_valid);
    end
  endtask

  task automatic test_jump();
    apply(0, 0, 1, 0, 32'h300, 1, 32'h400, 0, 0);
    fetch_pc(32'h300);
    vectors += 3;
    if (bus.predict_taken !== 1'b1) begin
      miscompares++; $display("FAIL jmp_taken got %0b want 1", bus.predict_taken);
    end
    if (bus.predict_pc !== 32'h400) begin
      miscompares++; $display("FAIL jmp_pc got %h want 400", bus.predict_pc);
    end
    if (bus.predict_ghr !== 8'd0) begin
      miscompares++; $display("FAIL jmp_ghr got %h want 0", bus.predict_ghr);
    end
    fetch_pc(32'h300);
    vectors++;
    if (bus.predict_ghr !== 8'd0) begin
      miscompares++; $display("FAIL jmp_noshift got %h want 0", bus.predict_ghr);
    end
  endtask

  task automatic test_ghr();
    logic [7:0] want [3];
    want[0] = 8'd0;
    want[1] = 8'd1;
    want[2] = 8'd3;
    for (int r = 0; r < 3; r++) begin
      resolve_br(32'h100, 1, 32'h200, 8'd0);
      resolve_br(32'h100, 1, 32'h200, 8'd1);
      resolve_br(32'h100, 1, 32'h200, 8'd3);
    end
    set_ghr(0);
    for (int i = 0; i < 3; i++) begin
      fetch_pc(32'h100);
      vectors += 2;
      if (bus.predict_ghr !== want[i]) begin
        miscompares++; $display("FAIL ghr_shift%0d got %h want %h", i, bus.predict_ghr, want[i]);
      end
      if (bus.predict_taken !== 1'b1) begin
        miscompares++; $display("FAIL ghr_taken%0d got %0b want 1", i, bus.predict_taken);
      end
    end
    apply(0, 0, 1, 1, 32'h100, 0, 32'h200, 8'd1, 1);
    fetch_pc(32'h100);
    vectors++;
    if (bus.predict_ghr !== 8'd2) begin
      miscompares++; $display("FAIL ghr_repair got %h want 02", bus.predict_ghr);
    end
  endtask

  task automatic test_collision();
    set_ghr(0);
    resolve_br(32'h100, 0, 32'h200, 0);
    resolve_br(32'h100, 0, 32'h200, 0);
    // Counter now weakly not-taken; train up in the same cycle as the lookup
    apply(1, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 0);
    vectors += 2;
    if (bus.predict_taken !== 1'b0) begin
      miscompares++; $display("FAIL pht_bypass got %0b want 0", bus.predict_taken);
    end
    if (bus.predict_taken !== e_taken) begin
      miscompares++; $display("FAIL pht_bypass_model got %0b want %0b", bus.predict_taken, e_taken);
    end
    fetch_pc(32'h100);
    vectors++;
    if (bus.predict_taken !== 1'b1) begin
      miscompares++; $display("FAIL pht_after got %0b want 1", bus.predict_taken);
    end
    // 0x300 shares BTB index 0 with 0x100
    apply(1, 32'h100, 1, 0, 32'h300, 1, 32'h400, 0, 0);
    vectors += 2;
    if (bus.predict_valid !== 1'b1) begin
      miscompares++; $display("FAIL btb_bypass_valid got %0b want 1", bus.predict_valid);
    end
    if (bus.predict_pc !== 32'h200) begin
      miscompares++; $display("FAIL btb_bypass_pc got %h want 200", bus.predict_pc);
    end
    fetch_pc(32'h100);
    vectors++;
    if (bus.predict_valid !== 1'b0) begin
      miscompares++; $display("FAIL btb_overwrite got %0b want 0", bus.predict_valid);
    end
  endtask

  task automatic test_reset_mid();
    resolve_br(32'h100, 1, 32'h200, 8'(m_ghr));
    fetch_pc(32'h100);
    vectors++;
    if (bus.predict_valid !== 1'b1) begin
      miscompares++; $display("FAIL pre_rst_valid got %0b want 1", bus.predict_valid);
    end
    rst_n = 1'b0;
    apply(1, 32'h100, 1, 1, 32'h700, 1, 32'h800, 8'h55, 1);
    rst_n = 1'b1;
    vectors += 4;
    if (bus.predict_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_valid got %0b want 0", bus.predict_valid);
    end
    if (bus.predict_taken !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_taken got %0b want 0", bus.predict_taken);
    end
    if (bus.predict_pc !== 32'd0) begin
      miscompares++; $display("FAIL mid_rst_pc got %h want 0", bus.predict_pc);
    end
    if (bus.predict_ghr !== 8'd0) begin
      miscompares++; $display("FAIL mid_rst_ghr got %h want 0", bus.predict_ghr);
    end
    fetch_pc(32'h100);
    vectors++;
    if (bus.predict_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_rst_hit got %0b want 0", bus.predict_valid);
    end
    fetch_pc(32'h700);
    vectors++;
    if (bus.predict_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_ignores_exe got %0b want 0", bus.predict_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs [6];
    logic [31:0] fpc, epc, tgt;
    bit          f, ev, br, tk, mp;
    logic [7:0]  eg;
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h300;
    pcs[3] = 32'h140; pcs[4] = 32'h2100; pcs[5] = 32'h13c;
    for (int n = 0; n < 400; n++) begin
      f   = ($urandom_range(0, 9) < 7);
      fpc = pcs[$urandom_range(0, 5)];
      ev  = $urandom_range(0, 1);
      br  = ($urandom_range(0, 3) != 0);
      epc = pcs[$urandom_range(0, 5)];
      tk  = $urandom_range(0, 1);
      tgt = $urandom() & 32'hffff_fffc;
      eg  = ($urandom_range(0, 1) != 0) ? 8'(m_ghr) : 8'($urandom());
      mp  = ($urandom_range(0, 4) == 0);
      apply(f, fpc, ev, br, epc, tk, tgt, eg, mp);
      vectors += 4;
      if (bus.predict_taken !== e_taken) begin
        miscompares++; $display("FAIL rnd_taken@%0d got %0b want %0b", n, bus.predict_taken, e_taken);
      end
      if (bus.predict_valid !== e_valid) begin
        miscompares++; $display("FAIL rnd_valid@%0d got %0b want %0b", n, bus.predict_valid, e_valid);
      end
      if (bus.predict_pc !== e_pc) begin
        miscompares++; $display("FAIL rnd_pc@%0d got %h want %h", n, bus.predict_pc, e_pc);
      end
      if (bus.predict_ghr !== e_ghr) begin
        miscompares++; $display("FAIL rnd_ghr@%0d got %h want %h", n, bus.predict_ghr, e_ghr);
      end
    end
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst_n              = 1'b0;
    bus.fetch          = 1'b0;
    bus.fetch_pc       = '0;
    bus.exe_valid      = 1'b0;
    bus.exe_is_br      = 1'b0;
    bus.exe_pc         = '0;
    bus.exe_taken      = 1'b0;
    bus.exe_target     = '0;
    bus.exe_ghr        = '0;
    bus.exe_mispredict = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_train();
    test_jump();
    test_ghr();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gshare_bpu.md
# gshare_bpu

Parametrised successor to the single-table branch predictor. It pairs a configurable-width saturating-counter PHT, indexed by PC XOR global history, with a speculatively updated global history register (GHR) that is checkpointed per prediction and repaired on mispredict. It also has a direct-mapped BTB that tags entries as conditional branch or unconditional jump. It sits between the IFU (fetch-side lookup) and the jump/branch execute unit (resolve-side training).

## Interface
Parameters:
- PHT_DEPTH, 256, PHT entries; power of two; AW = log2(PHT_DEPTH).
- GHR_W, 8, history bits; 1 ≤ GHR_W ≤ AW; zero-extended to AW for the XOR.
- CNT_W, 2, counter width; ≥ 2.
- BTB_SIZE, 16, BTB entries; power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- fetch  in  1  lookup request.
- fetch_pc  in  32  PC to predict.
- predict_taken  out  1  redirect fetch; registered.
- predict_valid  out  1  BTB hit; registered.
- predict_pc  out  32  predicted target; registered.
- predict_ghr  out  GHR_W  GHR snapshot used for this lookup; travels with the instruction.
- exe_valid  in  1  a branch or jump resolved this cycle.
- exe_is_br  in  1  1 = conditional branch, 0 = unconditional jump.
- exe_pc  in  32  PC of the resolved instruction.
- exe_taken  in  1  actual direction.
- exe_target  in  32  actual target.
- exe_ghr  in  GHR_W  snapshot returned from predict_ghr.
- exe_mispredict  in  1  direction or target was wrong; qualified by exe_valid.

## Operation
- Lookup index: rd_idx = fetch_pc[2+:AW] ^ spec_ghr. Training index: wr_idx = exe_pc[2+:AW] ^ exe_ghr.
- BTB lookup: index = fetch_pc[2+:log2(BTB_SIZE)]; tag = the remaining upper PC bits [31:2+log2(BTB_SIZE)]. Hit requires the valid bit and a tag match.
- Prediction, on fetch:
  - BTB miss: predict_taken = 0, predict_valid = 0.
  - Hit on a jump entry: predict_taken = 1.
  - Hit on a branch entry: predict_taken = PHT[rd_idx] MSB.
  - predict_pc = BTB target. predict_ghr = spec_ghr before any shift.
- Speculative GHR: on fetch with a BTB hit on a branch entry, spec_ghr <= {spec_ghr[GHR_W-2:0], predicted direction}. Jumps and misses do not shift it. When GHR_W = 1, spec_ghr <= predicted direction.
- Training, on exe_valid && exe_is_br: PHT[wr_idx] saturating increment if taken, decrement if not. Saturation at 0 and 2^CNT_W−1 holds the value.
- BTB update, on exe_valid && exe_taken: write valid, tag, exe_target and type (branch/jump) into the indexed entry; this overwrites any existing entry. Not-taken resolves leave the BTB unchanged.
- Repair, on exe_valid && exe_mispredict:
  - Branch: spec_ghr <= {exe_ghr[GHR_W-2:0], exe_taken}.
  - Jump: spec_ghr <= exe_ghr.
  - Repair has priority over a same-cycle speculative shift.
- Reset:
  - All PHT counters = 2^(CNT_W−1)−1 (weakly not-taken; 01 for CNT_W = 2).
  - All BTB valid bits = 0.
  - spec_ghr = 0.
  - predict_taken, predict_valid, predict_pc and predict_ghr = 0.

## Timing
- Lookup latency is 1 cycle: fetch at cycle t gives outputs valid at t+1.
- The predict_* outputs hold their value while fetch = 0.
- Training and repair take effect at the clock edge that samples exe_valid. A lookup in the following cycle sees the new counter, BTB entry and GHR.
- Same-cycle read and write (rd_idx == wr_idx, or a BTB index collision): the lookup returns the pre-update value. There is no bypass.
- Same-cycle fetch and mispredict: the registered prediction is still produced; the IFU discards it on flush. spec_ghr takes the repaired value.
- Reset asserted mid-stream: at the next edge all state and outputs return to reset values, and in-flight exe_* inputs are ignored for that cycle.

## Structure
- Shared package bpu_pkg holds:
  - btb_entry_t: valid, tag, target, is_jmp.
  - A function giving the counter reset constant from CNT_W.
  - A saturating increment/decrement function.
- Sub-module gshare_btb: parametrised direct-mapped BTB with a registered read port and a single write port. It is instantiated once.
- The PHT stays in gshare_bpu as a flop array.

## Test plan
- Reset, then fetch 0x100 → next cycle predict_valid = 0, predict_taken = 0, predict_ghr = 0.
- Resolve a taken branch at 0x100 (target 0x200, exe_ghr = 0) twice, then fetch 0x100 with spec_ghr = 0 → predict_valid = 1, predict_pc = 0x200, predict_taken = 1. The counter went 01→10→11.
- Four further taken resolves, then fetch → counter stays 11. Then 3 not-taken resolves → 00, and fetch predicts not-taken.
- Resolve a taken jump at 0x300 → 0x400, then fetch 0x300 → predict_taken = 1. spec_ghr is unchanged afterwards.
- Fetch 0x100 three times with a predicted-taken branch hit → predict_ghr = 0, 1, 3. Then a mispredict with exe_ghr = 1 and exe_taken = 0 → the next predict_ghr = 2.
- Same-cycle exe_valid on wr_idx and fetch on a matching rd_idx → the prediction uses the old counter. Asserting rst_n = 0 for one cycle mid-sequence clears all outputs and BTB hits.
